pc_stack: RTL
=============

Name: pc_stack

Overview:
- 16-bit program counter with a small return-address stack.
- Sits directly downstream of the load-enabled DFF/register layer. It is built from load-gated flip-flop words and consumes their hold/load behaviour to produce the instruction address for the CPU.
- Supports hold, increment, absolute jump, call (jump and push return address) and return (pop into PC).

Parameters:
- WIDTH, 16, bit width of PC, jump target and stack entries.
- DEPTH, 4, number of return-stack entries (power of two, minimum 2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in  input  WIDTH  jump/call target address
- load  input  1  jump: PC <= in
- inc  input  1  increment: PC <= PC+1
- call  input  1  push PC+1, then PC <= in
- ret  input  1  pop: PC <= top of stack
- out  output  WIDTH  current PC (registered)
- stk_empty  output  1  stack holds 0 entries
- stk_full  output  1  stack holds DEPTH entries
- stk_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- While reset=1, immediately and regardless of clk:
  - out=0, stack pointer=0, stk_empty=1, stk_full=0, stk_err=0.
  - Stack entry contents are don't-care.
  - All command inputs are ignored.
- Release of reset mid-cycle: the first update happens on the next rising clk edge.
- All updates occur on the rising clk edge. out reflects the new value after that edge (1-cycle latency, same as DFF load semantics). No combinational path from inputs to out.
- Command priority, highest first (exactly one action per edge):
  1. ret:
     - If the stack is non-empty: out <= stack[sp-1]; sp <= sp-1.
     - If empty: out holds, sp holds, stk_err <= 1.
  2. call:
     - If not full: stack[sp] <= out+1 (mod 2^WIDTH); sp <= sp+1; out <= in.
     - If full: out holds, stack unchanged, stk_err <= 1. The jump is NOT taken.
  3. load: out <= in.
  4. inc: out <= out+1, wrapping from 2^WIDTH-1 to 0 with no flag.
  5. None asserted: out holds.
- ret and call asserted together: ret is executed and call is ignored; no error from the ignored call.
- load or inc asserted with call or ret: they are ignored.
- Stack pointer: range 0..DEPTH, width clog2(DEPTH)+1.
  - stk_empty = (sp==0), stk_full = (sp==DEPTH). Both are decoded from registered sp and change only with sp.
- stk_err is sticky. It is cleared only by reset.
- Pushed return address wraps: call at out=0xFFFF pushes 0x0000.
- Stack is LIFO. Entries above sp are don't-care and never observable on out.

Test Plan:
- Reset: reset=1 asynchronously mid-cycle with out=0x0123 -> out=0, stk_empty=1, stk_err=0 before the next clk edge. Deassert, hold 2 cycles -> out stays 0.
- Increment/wrap/jump: load in=0xFFFE, then inc for 3 edges -> out 0xFFFE, 0xFFFF, 0x0000, 0x0001. Then load in=0x0040 with inc=1 -> out=0x0040 (load beats inc).
- Nested call/ret: from out=0x0010, call in=0x0100, then inc, then call in=0x0200 -> stack {0x0011, 0x0102}. Then ret -> out=0x0102; ret -> out=0x0011; stk_empty=1, stk_err=0.
- Overflow: 4 calls (in=0x1000..0x1003) -> stk_full=1. 5th call in=0x2000 -> out stays 0x1003, stk_err=1. One ret -> out = 0x1002+1 = 0x1003 pushed by the 4th call, stk_full=0.
- Underflow and simultaneous commands: on an empty stack, ret with out=0x0050 -> out holds 0x0050, stk_err=1. After reset, call in=0x0300 at out=0x0007, then call=ret=1 with in=0x0400 -> ret wins, out=0x0008, sp=0.
- Stickiness: after stk_err=1, 10 normal inc/load cycles -> stk_err stays 1. Reset pulse -> stk_err=0.

Source files
------------

// File: rtl/pc_stack.sv
// pc_stack: program counter with a small LIFO return-address stack.
// Commands per edge, highest priority first: ret, call, load, inc, hold.
// Stack overflow (call while full) and underflow (ret while empty) set a
// sticky error flag and leave PC and stack untouched.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_next;
  logic [SPW-1:0]   sp_dec;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] out_inc;
  logic             push;
  logic             err_next;

  // Next-state decode: one action per edge, ret beats call beats load beats inc.
  // stk_empty/stk_full are registered decodes of sp, so they stand in for
  // (sp==0) and (sp==DEPTH) here.
  always_comb begin
    out_inc  = out + {{(WIDTH-1){1'b0}}, 1'b1};
    sp_dec   = sp - {{AW{1'b0}}, 1'b1};
    push     = 1'b0;
    err_next = stk_err;
    out_next = out;
    sp_next  = sp;
    if (ret) begin
      if (!stk_empty) begin
        out_next = stack[sp_dec[AW-1:0]];
        sp_next  = sp_dec;
      end else begin
        err_next = 1'b1;
      end
    end else if (call) begin
      if (!stk_full) begin
        push     = 1'b1;
        out_next = in;
        sp_next  = sp + {{AW{1'b0}}, 1'b1};
      end else begin
        err_next = 1'b1;
      end
    end else if (load) begin
      out_next = in;
    end else if (inc) begin
      out_next = out_inc;
    end else begin
      out_next = out;
    end
  end

  // PC, stack pointer and status flags; everything observable is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= {WIDTH{1'b0}};
      sp        <= {SPW{1'b0}};
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      out       <= out_next;
      sp        <= sp_next;
      stk_empty <= (sp_next == {SPW{1'b0}});
      stk_full  <= (sp_next == SP_MAX);
      stk_err   <= err_next;
    end
  end

  // Return-address storage; contents above sp are never read, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp[AW-1:0]] <= out_inc;
    end
  end

endmodule
